aes_encryption: RTL and testbench

Byte-serial AES-128 encryption core. It accepts a 128-bit key and a 128-bit plaintext block, one byte of each per cycle. It then runs the ten AES rounds iteratively, one round per cycle, with on-the-fly key expansion. Finally it streams the 128-bit ciphertext out one byte per cycle. It sits between a byte-wide host/link interface and any consumer of ciphertext.

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/aes_sbox.sv | 79 +++++++
 rtl/aes_encryption.sv | 130 +++++++++++++
 tb/tb_aes_encryption.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM state encoding, block/round constants,
// Rcon table and the GF(2^8) helpers used by the round datapath.
package aes_pkg;

  localparam int unsigned NUM_BYTES  = 16;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROUND  = 2'd2,
    ST_OUTPUT = 2'd3
  } aes_fsm_e;

  // Round constant for round r (1..10); zero elsewhere.
  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Multiply by x modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; col[31:24] is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Build option: AES_SBOX_LUT_EN selects a 256-entry constant table;
// otherwise the S-box is computed as GF(2^8) inverse plus affine transform.
// Ports: a - input byte, s - substituted byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

`ifdef AES_SBOX_LUT_EN
  always_comb begin
    s = 8'h00;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
  end
`else
  // GF(2^8) multiply, shift-and-add with xtime reduction.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc, sh;
    acc = 8'h00;
    sh  = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  logic [7:0] pw;
  logic [7:0] inv;

  // inv = a^254 = a^(2+4+...+128); naturally maps 0 to 0.
  always_comb begin
    pw  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
`endif

endmodule

// File: rtl/aes_encryption.sv
// Byte-serial AES-128 encryption core: loads key and plaintext MSB byte
// first, runs 11 round steps (initial AddRoundKey + 10 rounds) one per
// cycle with on-the-fly key expansion, then streams ciphertext MSB first.
// Build option: AES_SBOX_LUT_EN (see aes_sbox) selects the S-box style.
// Ports: clk, rst (async, active-high); key_byte/state_byte input bytes
// captured while load=1; enable starts a block from IDLE;
// state_out_byte ciphertext byte valid while ready=1.
module aes_encryption
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_byte,
  input  logic [7:0] state_byte,
  input  logic       enable,
  output logic [7:0] state_out_byte,
  output logic       load,
  output logic       ready
);

  aes_fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BLOCK_W-1:0]   state_q, state_d;
  logic [BLOCK_W-1:0]   key_q, key_d;
  logic [7:0]           out_d;
  logic                 load_d, ready_d;

  logic [BLOCK_W-1:0]   sub_bytes, round_body, round_key;
  logic [31:0]          rot_word, sub_word, temp_word;
  logic [31:0]          rk0, rk1, rk2, rk3;

  // SubBytes for the whole state.
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_state_sbox
    aes_sbox u_sbox (.a(state_q[8*i +: 8]), .s(sub_bytes[8*i +: 8]));
  end

  // SubWord for key expansion.
  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (.a(rot_word[8*i +: 8]), .s(sub_word[8*i +: 8]));
  end

  // Next round key from the current one, using Rcon of the round in flight.
  assign rot_word  = {key_q[23:0], key_q[31:24]};
  assign temp_word = sub_word ^ {rcon(cnt_q), 24'h000000};
  assign rk0       = key_q[127:96] ^ temp_word;
  assign rk1       = key_q[95:64]  ^ rk0;
  assign rk2       = key_q[63:32]  ^ rk1;
  assign rk3       = key_q[31:0]   ^ rk2;
  assign round_key = {rk0, rk1, rk2, rk3};

  // Final round skips MixColumns.
  assign round_body = (cnt_q == CNT_W'(NUM_ROUNDS)) ? shift_rows(sub_bytes)
                                                   : mix_columns(shift_rows(sub_bytes));

  // State, counter, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q          <= ST_IDLE;
      cnt_q          <= '0;
      state_q        <= '0;
      key_q          <= '0;
      state_out_byte <= 8'h00;
      load           <= 1'b0;
      ready          <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      key_q          <= key_d;
      state_out_byte <= out_d;
      load           <= load_d;
      ready          <= ready_d;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    key_d   = key_q;
    out_d   = state_out_byte;
    case (fsm_q)
      ST_IDLE: begin
        if (enable) begin
          fsm_d = ST_LOAD;
          cnt_d = '0;
        end
      end
      ST_LOAD: begin
        // Shift in MSB-first so byte 0 lands in bits 127:120 after 16 beats.
        state_d = {state_q[119:0], state_byte};
        key_d   = {key_q[119:0], key_byte};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
          fsm_d = ST_ROUND;
          cnt_d = '0;
        end
      end
      ST_ROUND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          state_d = state_q ^ key_q;
        end else begin
          key_d   = round_key;
          state_d = round_body ^ round_key;
        end
        if (cnt_q == CNT_W'(NUM_ROUNDS)) begin
          fsm_d = ST_OUTPUT;
          cnt_d = '0;
          out_d = state_d[127:120];
        end
      end
      ST_OUTPUT: begin
        // Ciphertext is shifted up so the next byte is always at 119:112.
        if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
          fsm_d = ST_IDLE;
        end else begin
          out_d   = state_q[119:112];
          state_d = {state_q[119:0], 8'h00};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
    load_d  = (fsm_d == ST_LOAD);
    ready_d = (fsm_d == ST_OUTPUT);
  end

endmodule

// File: tb/tb_aes_encryption.sv
// Self-checking bench for aes_encryption: known-answer vectors streamed
// through the byte interface, ciphertext checked by a scoreboard queue,
// plus load/ready timing, mid-round reset and back-to-back starts.
module tb_aes_encryption;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] key_byte;
  logic [7:0] state_byte;
  logic [7:0] state_out_byte;
  logic       load;
  logic       ready;

  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int         n_cmp  = 0;
  int         n_fail = 0;

  localparam logic [127:0] K1 = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] P1 = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [127:0] C1 = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C3 = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_encryption dut (
    .clk           (clk),
    .rst           (rst),
    .key_byte      (key_byte),
    .state_byte    (state_byte),
    .enable        (enable),
    .state_out_byte(state_out_byte),
    .load          (load),
    .ready         (ready)
  );

  // Scoreboard: every ready cycle pops one expected ciphertext byte.
  always @(negedge clk) begin
    n_cmp++;
    if (load && ready) begin
      n_fail++;
      $display("FAIL load_ready_exclusive: load=%0b ready=%0b, required not both high", load, ready);
    end
    if (ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %02h with no byte expected", state_out_byte);
      end else begin
        exp_byte = exp_q.pop_front();
        if (state_out_byte !== exp_byte) begin
          n_fail++;
          $display("FAIL ct_byte: got %02h, expected %02h", state_out_byte, exp_byte);
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // One full block. enable stays high for en_cycles load beats after E0.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] ct, input int en_cycles, input string tag);
    int load_cnt;
    int wait_cnt;
    int rdy_cnt;
    load_cnt = 0;
    wait_cnt = 0;
    rdy_cnt  = 0;
    for (int k = 0; k < 16; k++) exp_q.push_back(ct[127-8*k -: 8]);
    enable     = 1'b1;
    key_byte   = key[127:120];
    state_byte = pt[127:120];
    @(posedge clk); #1;
    n_cmp++;
    if (load !== 1'b1) begin
      n_fail++;
      $display("FAIL %s load_rise: load=%0b, expected 1 one cycle after enable sampled", tag, load);
    end
    for (int k = 0; k < 16; k++) begin
      enable     = (k < en_cycles);
      key_byte   = key[127-8*k -: 8];
      state_byte = pt[127-8*k -: 8];
      if (load === 1'b1) load_cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (load_cnt != 16 || load !== 1'b0) begin
      n_fail++;
      $display("FAIL %s load_window: high for %0d cycles then load=%0b, expected 16 then 0", tag, load_cnt, load);
    end
    while (ready !== 1'b1 && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    n_cmp++;
    if (wait_cnt != 11) begin
      n_fail++;
      $display("FAIL %s compute_latency: ready after %0d cycles, expected 11", tag, wait_cnt);
    end
    while (ready === 1'b1 && rdy_cnt < 40) begin
      rdy_cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (rdy_cnt != 16) begin
      n_fail++;
      $display("FAIL %s ready_width: ready high %0d cycles, expected 16", tag, rdy_cnt);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    enable     = 1'b0;
    key_byte   = 8'h00;
    state_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (load !== 1'b0 || ready !== 1'b0 || state_out_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: load=%0b ready=%0b out=%02h, expected 0/0/00", load, ready, state_out_byte);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (load !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: load=%0b ready=%0b, expected 0/0", load, ready);
    end
  endtask

  task automatic test_link_vector();
    run_block(K1, P1, C1, 0, "link_vector");
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (state_out_byte !== 8'h3a || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL out_hold: out=%02h ready=%0b, expected 3a held with ready 0", state_out_byte, ready);
    end
  endtask

  task automatic test_fips_vectors();
    run_block(K2, P2, C2, 0, "fips_c1");
    @(posedge clk); #1;
    run_block(K3, P3, C3, 0, "fips_b");
  endtask

  task automatic test_reset_mid_round();
    enable     = 1'b1;
    key_byte   = K2[127:120];
    state_byte = P2[127:120];
    @(posedge clk); #1;
    enable = 1'b0;
    for (int k = 0; k < 16; k++) begin
      key_byte   = K2[127-8*k -: 8];
      state_byte = P2[127-8*k -: 8];
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (load !== 1'b0 || ready !== 1'b0 || state_out_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: load=%0b ready=%0b out=%02h, expected 0/0/00", load, ready, state_out_byte);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (ready !== 1'b0 || load !== 1'b0) begin
      n_fail++;
      $display("FAIL aborted_block: load=%0b ready=%0b, expected core to stay idle", load, ready);
    end
    run_block(K3, P3, C3, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    run_block(K2, P2, C2, 100, "b2b_first");
    run_block(K1, P1, C1, 0, "b2b_second");
  endtask

  task automatic test_enable_drop();
    @(posedge clk); #1;
    run_block(K3, P3, C3, 8, "enable_drop");
  endtask

  initial begin
    test_reset();
    test_link_vector();
    test_fips_vectors();
    test_reset_mid_round();
    test_back_to_back();
    test_enable_drop();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d bytes still expected, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
